// File: rtl/cnu_pkg.sv
// Shared types for the check node unit: default widths and the compressed
// check-node record passed from the min-finder to the message generator.
package cnu_pkg;

    localparam int DATA_W = 9;
    localparam int D      = 7;
    localparam int MSG_W  = DATA_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] min;
        logic [DATA_W-1:0] min2;
        logic [D-1:0]      min_idx;
        logic [D-1:0]      sign_in;
        logic              parity;
    } cnu_rec_t;

endpackage

// File: rtl/cnu_rec_fifo.sv
// Synchronous record FIFO with wrap-around pointers and an occupancy count.
// Pushes while full and pops while empty are ignored.
module cnu_rec_fifo
    import cnu_pkg::*;
#(
    parameter type rec_t = cnu_rec_t,
    parameter int  DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  rec_t          i_data,
    input  logic          i_pop,
    output rec_t          o_data,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    rec_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cnu_msg_gen.sv
// Expands compressed check-node records into D sign-magnitude messages plus parity.
// Define CNU_OFFSET_EN to enable offset-min-sum with saturation at zero.
module cnu_msg_gen
    import cnu_pkg::*;
#(
    parameter int data_w = cnu_pkg::DATA_W,
    parameter int D      = cnu_pkg::D,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_w-1:0]       min,
    input  logic [data_w-1:0]       min2,
    input  logic [D-1:0]            min_idx,
    input  logic [D-1:0]            sign_in,
    input  logic [data_w-1:0]       offset,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(data_w+1)*D-1:0] msg_out,
    output logic                    out_parity
);

    localparam int EDGE_W = data_w + 1;
    localparam int CW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [data_w-1:0] min;
        logic [data_w-1:0] min2;
        logic [D-1:0]      min_idx;
        logic [D-1:0]      sign_in;
        logic              parity;
    } rec_t;

`ifdef CNU_OFFSET_EN
    function automatic logic [data_w-1:0] sat_sub(input logic [data_w-1:0] mag,
                                                  input logic [data_w-1:0] off);
        return (mag > off) ? (mag - off) : '0;
    endfunction
`else
    logic w_offset_unused;
    assign w_offset_unused = ^offset;
`endif

    rec_t                 w_rec_in;
    rec_t                 w_head;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic                 w_push;
    logic                 w_pop;
    logic [EDGE_W*D-1:0]  w_msg;

    logic                 r_vld_p1;
    logic [EDGE_W*D-1:0]  r_msg_p1;
    logic                 r_par_p1;

    assign in_ready = (32'(w_count) < DEPTH) && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && (!r_vld_p1 || out_ready);

    assign w_rec_in = '{min: min, min2: min2, min_idx: min_idx,
                        sign_in: sign_in, parity: ^sign_in};

    cnu_rec_fifo #(
        .rec_t (rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_rec_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Stage p0: per-edge expansion of the FIFO head record
    always_comb begin
        logic [data_w-1:0] v_mag;
        logic              v_sgn;
        w_msg = '0;
        for (int i = 0; i < D; i++) begin
            v_mag = w_head.min_idx[i] ? w_head.min2 : w_head.min;
`ifdef CNU_OFFSET_EN
            v_mag = sat_sub(v_mag, offset);
`endif
            // a zero magnitude is always emitted as positive zero
            v_sgn = (v_mag == '0) ? 1'b0 : (w_head.parity ^ w_head.sign_in[i]);
            w_msg[i*EDGE_W +: EDGE_W] = {v_sgn, v_mag};
        end
    end

    // Stage p1: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_msg_p1 <= '0;
            r_par_p1 <= 1'b0;
        end else if (w_pop) begin
            r_vld_p1 <= 1'b1;
            r_msg_p1 <= w_msg;
            r_par_p1 <= w_head.parity;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign out_valid  = r_vld_p1;
    assign msg_out    = r_msg_p1;
    assign out_parity = r_par_p1;

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Directed bench for cnu_msg_gen: expansion, sign product, offset, backpressure,
// reset mid-stream and a D=6 instance.
module tb_cnu_msg_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  min;
    logic [8:0]  min2;
    logic [6:0]  min_idx;
    logic [6:0]  sign_in;
    logic [8:0]  offset;
    logic        out_valid;
    logic        out_ready;
    logic [69:0] msg_out;
    logic        out_parity;

    logic        in6_valid;
    logic        in6_ready;
    logic [8:0]  min6;
    logic [8:0]  min2_6;
    logic [5:0]  idx6;
    logic [5:0]  sgn6;
    logic [8:0]  off6;
    logic        out6_valid;
    logic        out6_ready;
    logic [59:0] msg6_out;
    logic        par6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnu_msg_gen dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .min        (min),
        .min2       (min2),
        .min_idx    (min_idx),
        .sign_in    (sign_in),
        .offset     (offset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .msg_out    (msg_out),
        .out_parity (out_parity)
    );

    cnu_msg_gen #(.data_w(9), .D(6), .DEPTH(2)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in6_valid),
        .in_ready   (in6_ready),
        .min        (min6),
        .min2       (min2_6),
        .min_idx    (idx6),
        .sign_in    (sgn6),
        .offset     (off6),
        .out_valid  (out6_valid),
        .out_ready  (out6_ready),
        .msg_out    (msg6_out),
        .out_parity (par6)
    );

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] mn, input logic [8:0] mn2,
                         input logic [6:0] idx, input logic [6:0] sg);
        in_valid = 1'b1;
        min      = mn;
        min2     = mn2;
        min_idx  = idx;
        sign_in  = sg;
    endtask

    localparam logic [69:0] MSG_A = {10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd1, 10'd2};
    localparam logic [69:0] MSG_B = {10'h206, 10'h204, 10'h204, 10'h204, 10'h204, 10'd4, 10'h204};
    localparam logic [69:0] MSG_C = {10'd0, 10'd0, 10'd0, 10'd8, 10'd0, 10'd0, 10'd0};
    localparam logic [69:0] MSG_D = {10'h20A, 10'h20A, 10'h20A, 10'h20A, 10'd10, 10'h20A, 10'h20A};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        min = '0; min2 = '0; min_idx = '0; sign_in = '0; offset = '0;
        in6_valid = 1'b0; out6_ready = 1'b1; min6 = '0; min2_6 = '0;
        idx6 = '0; sgn6 = '0; off6 = '0;
        step();
        step();
        chk("rst_out_valid", 70'(out_valid), 70'd0);
        chk("rst_msg_out", msg_out, 70'd0);
        chk("rst_parity", 70'(out_parity), 70'd0);
        chk("rst_in_ready", 70'(in_ready), 70'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 70'(in_ready), 70'd1);

        // Basic expansion and two-cycle latency
        drive(9'd3, 9'd5, 7'b0000100, 7'b0000000);
        chk("s1_in_ready", 70'(in_ready), 70'd1);
        step();
        in_valid = 1'b0;
        chk("s1_valid_t1", 70'(out_valid), 70'd0);
        step();
        chk("s1_valid_t2", 70'(out_valid), 70'd1);
        chk("s1_msg", msg_out, {10'd3, 10'd3, 10'd3, 10'd3, 10'd5, 10'd3, 10'd3});
        chk("s1_parity", 70'(out_parity), 70'd0);

        // Sign product
        drive(9'd3, 9'd5, 7'b0000100, 7'b0000001);
        step();
        in_valid = 1'b0;
        step();
        chk("s2_msg", msg_out, {10'h203, 10'h203, 10'h203, 10'h203, 10'h205, 10'h203, 10'd3});
        chk("s2_parity", 70'(out_parity), 70'd1);
        step();
        chk("s2_drained", 70'(out_valid), 70'd0);

        // Offset correction (plain min-sum expected when the macro is off)
        offset = 9'd4;
        drive(9'd3, 9'd5, 7'b0000100, 7'b0000011);
        step();
        in_valid = 1'b0;
        step();
`ifdef CNU_OFFSET_EN
        chk("s3_msg", msg_out, {10'd0, 10'd0, 10'd0, 10'd0, 10'd1, 10'd0, 10'd0});
`else
        chk("s3_msg", msg_out, {10'd3, 10'd3, 10'd3, 10'd3, 10'd5, 10'h203, 10'h203});
`endif
        chk("s3_parity", 70'(out_parity), 70'd0);
        offset = 9'd0;
        step();
        chk("s3_drained", 70'(out_valid), 70'd0);

        // Backpressure: A, B, C accepted, D refused until the stall lifts
        out_ready = 1'b0;
        drive(9'd1, 9'd2, 7'b0000001, 7'b0000000);
        chk("s4_rdy_a", 70'(in_ready), 70'd1);
        step();
        drive(9'd4, 9'd6, 7'b1000000, 7'b0000010);
        chk("s4_rdy_b", 70'(in_ready), 70'd1);
        step();
        drive(9'd0, 9'd8, 7'b0001000, 7'b0000011);
        chk("s4_rdy_c", 70'(in_ready), 70'd1);
        chk("s4_hold_valid", 70'(out_valid), 70'd1);
        chk("s4_hold_a0", msg_out, MSG_A);
        step();
        drive(9'd10, 9'd20, 7'b0000000, 7'b0000100);
        chk("s4_rdy_d_low", 70'(in_ready), 70'd0);
        chk("s4_hold_a1", msg_out, MSG_A);
        step();
        chk("s4_rdy_d_low2", 70'(in_ready), 70'd0);
        chk("s4_hold_a2", msg_out, MSG_A);
        chk("s4_par_a", 70'(out_parity), 70'd0);
        out_ready = 1'b1;
        step();
        chk("s4_out_b", msg_out, MSG_B);
        chk("s4_par_b", 70'(out_parity), 70'd1);
        chk("s4_rdy_d_high", 70'(in_ready), 70'd1);
        step();
        in_valid = 1'b0;
        chk("s4_out_c", msg_out, MSG_C);
        chk("s4_valid_c", 70'(out_valid), 70'd1);
        step();
        chk("s4_out_d", msg_out, MSG_D);
        chk("s4_par_d", 70'(out_parity), 70'd1);
        step();
        chk("s4_drained", 70'(out_valid), 70'd0);

        // Reset with two records buffered
        out_ready = 1'b0;
        drive(9'd1, 9'd2, 7'b0000001, 7'b0000000);
        step();
        drive(9'd4, 9'd6, 7'b1000000, 7'b0000010);
        step();
        in_valid = 1'b0;
        chk("s5_pre_valid", 70'(out_valid), 70'd1);
        rst = 1'b1;
        step();
        chk("s5_rst_valid", 70'(out_valid), 70'd0);
        chk("s5_rst_msg", msg_out, 70'd0);
        chk("s5_rst_in_ready", 70'(in_ready), 70'd0);
        rst = 1'b0;
        #1;
        chk("s5_in_ready", 70'(in_ready), 70'd1);
        out_ready = 1'b1;
        step();
        chk("s5_no_stale0", 70'(out_valid), 70'd0);
        step();
        step();
        chk("s5_no_stale1", 70'(out_valid), 70'd0);

        // D=6 instance with all-zero min index
        in6_valid = 1'b1; min6 = 9'd7; min2_6 = 9'd9; idx6 = 6'b000000; sgn6 = 6'b000000;
        step();
        in6_valid = 1'b0;
        step();
        chk("s6_valid", 70'(out6_valid), 70'd1);
        chk("s6_msg", 70'(msg6_out), 70'({10'd7, 10'd7, 10'd7, 10'd7, 10'd7, 10'd7}));
        chk("s6_parity", 70'(par6), 70'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
